switch_rx_frame_parser: RTL and testbench
=========================================

# switch_rx_frame_parser

Receiving end of the switch input port protocol. Samples the `data_status`/`data_in` byte stream driven on a switch input port, then parses and checks each packet (destination address, source address, length, payload, FCS). Good packets are stored in a commit/rollback frame buffer and forwarded as a valid/ready byte stream tagged with the destination port index. Bad packets are discarded and flagged. Sits at each switch input port, ahead of the crossbar arbiter.

## Interface
- `DEPTH`, 64: frame buffer entries (bytes); power of two, ≥ 4+MAX_LEN
- `MAX_LEN`, 32: largest legal payload length
- `NUM_PORTS`, 4: number of output ports / address registers (fixed at 4 in this release)
- `clock` input 1: single clock; all logic on posedge
- `reset` input 1: synchronous, active-low
- `data_status` input 1: high for every byte of a packet, low between packets
- `data_in` input 8: packet byte, valid when `data_status`=1
- `port_addr` input 4x8 (packed 32): address of output port i in bits [8i+7:8i]
- `out_valid` output 1: buffered byte available
- `out_ready` input 1: consumer accepts byte when `out_valid`&&`out_ready`
- `out_data` output 8: packet byte (DA..FCS, as received)
- `out_sop`, `out_eop` output 1 each: first/last byte of packet
- `out_port` output 2: destination port index for the whole packet
- `err_fcs`, `err_len`, `err_da`, `err_ovf` output 1 each: one-cycle error pulses
- `pkt_good` output 1: one-cycle pulse on commit

## Operation
- Packet: DA, SA, LEN, LEN payload bytes, FCS. FCS = XOR of DA, SA, LEN and all payload bytes.
- FSM states: SYNC, IDLE, SA, LEN, PAYLOAD, FCS, GAP, DROP.
  - SYNC (after reset): wait for `data_status`=0, then go to IDLE. Guarantees no partial packet is accepted after reset.
  - IDLE: a sampled byte with `data_status`=1 is DA.
    - If DA matches a `port_addr` entry, capture the lowest matching index, write the entry, go to SA.
    - Otherwise pulse `err_da` and go to DROP.
  - SA → LEN: write each byte.
  - LEN: LEN=0 or LEN>MAX_LEN gives `err_len` and DROP. Otherwise load the payload counter and go to PAYLOAD.
  - PAYLOAD: write bytes and decrement the counter. After the last payload byte, go to FCS.
  - FCS: compare the sampled byte with the running XOR.
    - Match: write the byte with eop, commit, pulse `pkt_good`.
    - Mismatch: roll back, pulse `err_fcs`.
    - Either way, go to GAP.
  - GAP: wait for `data_status`=0, then go to IDLE. Any byte sampled here pulses `err_len` once. The committed packet stays committed.
  - DROP: roll back, ignore bytes until `data_status`=0, then go to IDLE.
- Truncation: `data_status`=0 in SA/LEN/PAYLOAD/FCS gives `err_len`, rollback, IDLE.
- Overflow: a write when speculative fill = DEPTH gives `err_ovf`, rollback, DROP. There is no input backpressure.
- Buffer entry = {port[1:0], sop, eop, data[7:0]}. The read side presents only committed entries.
- Error pulses are mutually exclusive per packet: the first error detected wins.

## Timing
- `data_in` and `data_status` are sampled at posedge. The driver updates them after hold time.
- Commit occurs at the edge that samples a good FCS byte.
- `out_valid` for that packet's DA rises no earlier than the next cycle (store-and-forward latency 1 cycle after FCS).
- `out_*` holds stable while `out_valid`&&!`out_ready`.
- Same-cycle commit and read is legal. Same-cycle rollback and read is legal; the read affects only committed data.
- Fill = wr_spec − rd, with pointers of width log2(DEPTH)+1. Wrap is handled by the extra MSB.
- Reset values: `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_data`=0, `out_port`=0, all error pulses 0, `pkt_good`=0, pointers 0, state SYNC.
- Reset mid-packet: buffered and partial data are lost, state goes to SYNC.

## Structure
- Package `switch_rx_pkg`:
  - state enum
  - header offsets
  - buffer entry struct
  - `NUM_PORTS`
  - FCS update function
- Sub-module `switch_rx_frame_fifo`: DEPTH-entry FIFO with speculative write pointer, commit pointer, read pointer, and commit/rollback/full controls.

## Test plan
- `port_addr`={8'h44,8'h33,8'h22,8'h11}; send DA=22, SA=05, LEN=3, payload 01 02 03, FCS=24 → `pkt_good` pulse; 7 bytes out with `out_port`=1, sop on 22, eop on 24.
- Same packet with FCS=25 → `err_fcs`; nothing output; next good packet passes intact.
- DA=99 → `err_da`; LEN=0 and LEN=33 → `err_len`; `data_status` dropped after 2 payload bytes → `err_len`; no output in any case.
- Hold `out_ready`=0; stream good 36-byte packets until full → `err_ovf` on the overflowing packet. Earlier packets drain byte-exact once `out_ready`=1.
- Assert `reset` low mid-payload, release it with `data_status` still high → remaining bytes ignored; the next packet after a low gap is accepted.
- Random `out_ready` backpressure with back-to-back gapped packets → output byte sequence equals the input good-packet sequence; sop/eop counts match.

Source files
------------

// File: rtl/switch_rx_pkg.sv
// Shared types and helpers for the switch input-port receive path.
//   rx_state_t   : parser FSM states
//   HDR_*        : byte offsets of the header fields within a packet
//   buf_entry_t  : one frame-buffer entry {port, sop, eop, data}
//   fcs_update() : running frame check (byte-wise XOR)
package switch_rx_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;

  localparam int HDR_DA    = 0;
  localparam int HDR_SA    = 1;
  localparam int HDR_LEN   = 2;
  localparam int HDR_BYTES = 3;

  typedef enum logic [2:0] {
    S_SYNC, S_IDLE, S_SA, S_LEN, S_PAYLOAD, S_FCS, S_GAP, S_DROP
  } rx_state_t;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic              sop;
    logic              eop;
    logic [7:0]        data;
  } buf_entry_t;

  function automatic logic [7:0] fcs_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/switch_rx_frame_fifo.sv
// Frame buffer with speculative write. Bytes of the packet being received
// land at wr_spec; commit publishes them to the reader (wr_cmt), rollback
// discards them. The reader only ever sees [rd, wr_cmt).
//   wr_en/wr_entry : speculative write
//   commit         : publish everything written so far, incl. this cycle's write
//   rollback       : drop everything written since the last commit
//   full           : speculative fill == DEPTH
//   rd_en/rd_valid/rd_entry : committed read side, rd_entry valid when rd_valid
module switch_rx_frame_fifo import switch_rx_pkg::*; #(
  parameter int DEPTH = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  buf_entry_t wr_entry,
  input  logic       commit,
  input  logic       rollback,
  output logic       full,
  input  logic       rd_en,
  output logic       rd_valid,
  output buf_entry_t rd_entry
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB distinguishes full from empty after wrap.
  logic [AW:0] wr_spec, wr_cmt, rd, fill;
  buf_entry_t  mem [DEPTH];

  assign fill     = wr_spec - rd;
  assign full     = (fill == (AW+1)'(DEPTH));
  assign rd_valid = (rd != wr_cmt);
  assign rd_entry = mem[rd[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_spec <= '0;
      wr_cmt  <= '0;
      rd      <= '0;
    end else begin
      if (rollback)   wr_spec <= wr_cmt;
      else if (wr_en) wr_spec <= wr_spec + 1'b1;
      if (commit)     wr_cmt  <= wr_en ? wr_spec + 1'b1 : wr_spec;
      if (rd_en && rd_valid) rd <= rd + 1'b1;
    end
  end

  always_ff @(posedge clock)
    if (wr_en) mem[wr_spec[AW-1:0]] <= wr_entry;

endmodule

// File: rtl/switch_rx_frame_parser.sv
// Switch input-port receiver: parses DA/SA/LEN/payload/FCS from the
// data_status/data_in stream, buffers good packets store-and-forward and
// streams them out tagged with the destination port index.
//   clock, reset (sync, active-low)
//   data_status, data_in : input byte stream
//   port_addr            : per-output-port address, port i at [8i+7:8i]
//   out_valid/out_ready/out_data/out_sop/out_eop/out_port : output stream
//   err_fcs/err_len/err_da/err_ovf, pkt_good : one-cycle status pulses
module switch_rx_frame_parser import switch_rx_pkg::*; #(
  parameter int DEPTH     = 64,
  parameter int MAX_LEN   = 32,
  parameter int NUM_PORTS = switch_rx_pkg::NUM_PORTS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   data_status,
  input  logic [7:0]             data_in,
  input  logic [NUM_PORTS*8-1:0] port_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [PORT_W-1:0]      out_port,
  output logic                   err_fcs,
  output logic                   err_len,
  output logic                   err_da,
  output logic                   err_ovf,
  output logic                   pkt_good
);
  rx_state_t         state, state_n;
  logic [PORT_W-1:0] port_q, port_n, hit_idx;
  logic [7:0]        cnt, cnt_n, fcs, fcs_n;
  logic              gap_err, gap_err_n, hit;
  logic              wr_en, commit, rollback, full, rd_valid;
  logic              e_fcs, e_len, e_da, e_ovf, good;
  buf_entry_t        wr_entry, rd_entry;

  // Lowest matching port wins: scan high to low so low indices override.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--)
      if (port_addr[i*8 +: 8] == data_in) begin
        hit     = 1'b1;
        hit_idx = PORT_W'(i);
      end
  end

  always_comb begin
    state_n   = state;
    port_n    = port_q;
    cnt_n     = cnt;
    fcs_n     = fcs;
    gap_err_n = gap_err;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    e_fcs     = 1'b0;
    e_len     = 1'b0;
    e_da      = 1'b0;
    e_ovf     = 1'b0;
    good      = 1'b0;
    wr_entry  = '{port: port_q, sop: 1'b0, eop: 1'b0, data: data_in};
    case (state)
      S_SYNC: if (!data_status) state_n = S_IDLE;
      S_IDLE: if (data_status) begin
        if (!hit) begin
          e_da    = 1'b1;
          state_n = S_DROP;
        end else if (full) begin
          e_ovf    = 1'b1;
          rollback = 1'b1;
          state_n  = S_DROP;
        end else begin
          wr_en         = 1'b1;
          wr_entry.port = hit_idx;
          wr_entry.sop  = 1'b1;
          port_n        = hit_idx;
          fcs_n         = data_in;
          state_n       = S_SA;
        end
      end
      S_SA, S_LEN, S_PAYLOAD: begin
        if (!data_status) begin
          e_len    = 1'b1;
          rollback = 1'b1;
          state_n  = S_IDLE;
        end else if (state == S_LEN && (data_in == 8'd0 || data_in > 8'(MAX_LEN))) begin
          e_len    = 1'b1;
          rollback = 1'b1;
          state_n  = S_DROP;
        end else if (full) begin
          e_ovf    = 1'b1;
          rollback = 1'b1;
          state_n  = S_DROP;
        end else begin
          wr_en = 1'b1;
          fcs_n = fcs_update(fcs, data_in);
          case (state)
            S_SA:  state_n = S_LEN;
            S_LEN: begin
              cnt_n   = data_in;
              state_n = S_PAYLOAD;
            end
            default: begin
              cnt_n = cnt - 8'd1;
              if (cnt == 8'd1) state_n = S_FCS;
            end
          endcase
        end
      end
      S_FCS: begin
        if (!data_status) begin
          e_len    = 1'b1;
          rollback = 1'b1;
          state_n  = S_IDLE;
        end else if (data_in != fcs) begin
          // The packet already carries an error: a trailing byte in GAP
          // must not raise a second one.
          e_fcs     = 1'b1;
          rollback  = 1'b1;
          gap_err_n = 1'b1;
          state_n   = S_GAP;
        end else if (full) begin
          e_ovf    = 1'b1;
          rollback = 1'b1;
          state_n  = S_DROP;
        end else begin
          wr_en        = 1'b1;
          wr_entry.eop = 1'b1;
          commit       = 1'b1;
          good         = 1'b1;
          gap_err_n    = 1'b0;
          state_n      = S_GAP;
        end
      end
      S_GAP: begin
        if (!data_status) state_n = S_IDLE;
        else if (!gap_err) begin
          e_len     = 1'b1;
          gap_err_n = 1'b1;
        end
      end
      default: begin  // S_DROP
        rollback = 1'b1;
        if (!data_status) state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_SYNC;
      port_q   <= '0;
      cnt      <= '0;
      fcs      <= '0;
      gap_err  <= 1'b0;
      err_fcs  <= 1'b0;
      err_len  <= 1'b0;
      err_da   <= 1'b0;
      err_ovf  <= 1'b0;
      pkt_good <= 1'b0;
    end else begin
      state    <= state_n;
      port_q   <= port_n;
      cnt      <= cnt_n;
      fcs      <= fcs_n;
      gap_err  <= gap_err_n;
      err_fcs  <= e_fcs;
      err_len  <= e_len;
      err_da   <= e_da;
      err_ovf  <= e_ovf;
      pkt_good <= good;
    end
  end

  switch_rx_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_entry (wr_entry),
    .commit   (commit),
    .rollback (rollback),
    .full     (full),
    .rd_en    (out_ready),
    .rd_valid (rd_valid),
    .rd_entry (rd_entry)
  );

  // Gate with rd_valid so outputs read as zero whenever nothing is committed.
  assign out_valid = rd_valid;
  assign out_data  = rd_valid ? rd_entry.data : '0;
  assign out_sop   = rd_valid & rd_entry.sop;
  assign out_eop   = rd_valid & rd_entry.eop;
  assign out_port  = rd_valid ? rd_entry.port : '0;

endmodule

// File: tb/tb_switch_rx_frame_parser.sv
module tb_switch_rx_frame_parser;
  localparam int DEPTH   = 64;
  localparam int MAX_LEN = 32;

  logic        clock = 1'b0, reset = 1'b0, data_status = 1'b0, out_ready = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [31:0] port_addr = '0;
  logic        out_valid, out_sop, out_eop, err_fcs, err_len, err_da, err_ovf, pkt_good;
  logic [7:0]  out_data;
  logic [1:0]  out_port;

  switch_rx_frame_parser #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .NUM_PORTS(4)) dut (
    .clock(clock), .reset(reset), .data_status(data_status), .data_in(data_in),
    .port_addr(port_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port),
    .err_fcs(err_fcs), .err_len(err_len), .err_da(err_da), .err_ovf(err_ovf),
    .pkt_good(pkt_good));

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int n_good = 0, n_fcs = 0, n_len = 0, n_da = 0, n_ovf = 0;
  int ready_mode = 1;  // 0 stall, 1 always ready, 2 random
  logic [10:0] got_q[$], exp_q[$];
  logic [7:0]  pkt[$];
  logic [7:0]  addr_tab[4];

  // Consumer: ready changes just after the active edge.
  initial forever begin
    @(posedge clock); #1;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor on the falling edge: accepted bytes and status pulses.
  initial forever begin
    @(negedge clock);
    if (out_valid && out_ready) got_q.push_back({out_port, out_sop, out_eop, out_data});
    if (pkt_good) n_good++;
    if (err_fcs)  n_fcs++;
    if (err_len)  n_len++;
    if (err_da)   n_da++;
    if (err_ovf)  n_ovf++;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic [39:0] pulses();
    return {n_good[7:0], n_fcs[7:0], n_len[7:0], n_da[7:0], n_ovf[7:0]};
  endfunction

  task automatic set_addrs(input logic [7:0] a0, a1, a2, a3);
    addr_tab[0] = a0; addr_tab[1] = a1; addr_tab[2] = a2; addr_tab[3] = a3;
    port_addr = {a3, a2, a1, a0};
  endtask

  // Reference lookup: lowest table index holding this address.
  function automatic int lookup(input logic [7:0] da);
    for (int i = 0; i < 4; i++) if (addr_tab[i] == da) return i;
    return -1;
  endfunction

  function automatic logic [7:0] miss_addr();
    logic [7:0] a;
    do a = 8'($urandom); while (lookup(a) >= 0);
    return a;
  endfunction

  task automatic build_pkt(input logic [7:0] da, input logic [7:0] sa, input int len, input bit bad);
    logic [7:0] x;
    pkt.delete();
    pkt.push_back(da); pkt.push_back(sa); pkt.push_back(8'(len));
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    x = 8'h00;
    foreach (pkt[i]) x ^= pkt[i];
    if (bad) x ^= 8'(1 << $urandom_range(0, 7));
    pkt.push_back(x);
  endtask

  task automatic push_exp();
    int p;
    p = lookup(pkt[0]);
    foreach (pkt[i]) exp_q.push_back({2'(p), i == 0, i == pkt.size() - 1, pkt[i]});
  endtask

  task automatic send(input int nb, input int gap);
    for (int i = 0; i < nb; i++) begin
      data_status = 1'b1; data_in = pkt[i]; tick();
    end
    data_status = 1'b0; data_in = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic drain(output bit to);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin tick(); n++; end
    to = (n >= 3000);
    repeat (6) tick();
  endtask

  function automatic int stream_diff(output int at);
    int bad = 0;
    at = -1;
    if (got_q.size() != exp_q.size()) begin bad++; at = 0; end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin if (at < 0) at = i; bad++; end
    return bad;
  endfunction

  task automatic clear_q();
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; data_status = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
    checks++; if ({out_sop, out_eop} !== 2'b00) begin errors++; $display("FAIL reset_sop_eop got %b exp 00", {out_sop, out_eop}); end
    checks++; if (out_port !== 2'd0) begin errors++; $display("FAIL reset_port got %0d exp 0", out_port); end
    checks++; if ({err_fcs, err_len, err_da, err_ovf, pkt_good} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got %b exp 00000", {err_fcs, err_len, err_da, err_ovf, pkt_good}); end
    tick(); reset = 1'b1; repeat (2) tick();
  endtask

  task automatic test_good();
    logic [39:0] p0; bit to; int at;
    set_addrs(8'h11, 8'h22, 8'h33, 8'h44);
    ready_mode = 1; clear_q(); p0 = pulses();
    pkt = '{8'h22, 8'h05, 8'h03, 8'h01, 8'h02, 8'h03, 8'h24};
    push_exp();
    for (int i = 0; i < 7; i++) begin
      data_status = 1'b1; data_in = pkt[i];
      if (i == 6) begin
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %b exp 0", out_valid); end
      end
      tick();
    end
    data_status = 1'b0; repeat (2) tick();
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL good_timeout got %0d bytes exp %0d", got_q.size(), exp_q.size()); end
    checks++; if (stream_diff(at) != 0) begin errors++; $display("FAIL good_stream got %0d bytes exp %0d first diff %0d", got_q.size(), exp_q.size(), at); end
    checks++; if (pulses() - p0 !== 40'h01_00_00_00_00) begin errors++; $display("FAIL good_pulses got %h exp 0100000000", pulses() - p0); end
  endtask

  task automatic test_bad_fcs();
    logic [39:0] p0; bit to; int at;
    clear_q(); p0 = pulses();
    pkt = '{8'h22, 8'h05, 8'h03, 8'h01, 8'h02, 8'h03, 8'h25};
    send(7, 2);
    build_pkt(8'h44, 8'h09, 5, 0); push_exp(); send(pkt.size(), 2);
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL fcs_timeout got %0d bytes exp %0d", got_q.size(), exp_q.size()); end
    checks++; if (stream_diff(at) != 0) begin errors++; $display("FAIL fcs_stream got %0d bytes exp %0d first diff %0d", got_q.size(), exp_q.size(), at); end
    checks++; if (pulses() - p0 !== 40'h01_01_00_00_00) begin errors++; $display("FAIL fcs_pulses got %h exp 0101000000", pulses() - p0); end
  endtask

  task automatic test_errors();
    logic [39:0] p0; bit to;
    clear_q(); p0 = pulses();
    build_pkt(8'h99, 8'h05, 3, 0);           send(pkt.size(), 2);
    build_pkt(8'h22, 8'h05, 0, 0);           send(pkt.size(), 2);
    build_pkt(8'h33, 8'h05, MAX_LEN + 1, 0); send(pkt.size(), 2);
    build_pkt(8'h44, 8'h05, 5, 0);           send(5, 2);
    drain(to);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL err_output got %0d bytes exp 0", got_q.size()); end
    checks++; if (pulses() - p0 !== 40'h00_00_03_01_00) begin errors++; $display("FAIL err_pulses got %h exp 0000030100", pulses() - p0); end
  endtask

  task automatic test_overflow();
    logic [39:0] p0; logic [10:0] s0, s1; bit to; int at;
    clear_q(); p0 = pulses();
    ready_mode = 0; tick();
    build_pkt(8'h11, 8'h01, MAX_LEN, 0); push_exp(); send(pkt.size(), 2);
    build_pkt(8'h33, 8'h02, MAX_LEN, 0); send(pkt.size(), 2);
    @(negedge clock); s0 = {out_port, out_sop, out_eop, out_data};
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", out_valid); end
    repeat (5) @(negedge clock);
    s1 = {out_port, out_sop, out_eop, out_data};
    checks++; if (s1 !== exp_q[0]) begin errors++; $display("FAIL stall_hold got %h exp %h (first %h)", s1, exp_q[0], s0); end
    tick(); ready_mode = 1;
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL ovf_timeout got %0d bytes exp %0d", got_q.size(), exp_q.size()); end
    checks++; if (stream_diff(at) != 0) begin errors++; $display("FAIL ovf_stream got %0d bytes exp %0d first diff %0d", got_q.size(), exp_q.size(), at); end
    checks++; if (pulses() - p0 !== 40'h01_00_00_00_01) begin errors++; $display("FAIL ovf_pulses got %h exp 0100000001", pulses() - p0); end
  endtask

  task automatic test_reset_mid();
    logic [39:0] p0; bit to; int at;
    clear_q(); p0 = pulses();
    build_pkt(8'h22, 8'h07, 5, 0);
    send(5, 0);
    data_status = 1'b1; data_in = pkt[5]; reset = 1'b0; tick();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    for (int i = 6; i < pkt.size(); i++) begin data_status = 1'b1; data_in = pkt[i]; tick(); end
    data_status = 1'b0; repeat (2) tick();
    build_pkt(8'h33, 8'h08, 4, 0); push_exp(); send(pkt.size(), 2);
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_timeout got %0d bytes exp %0d", got_q.size(), exp_q.size()); end
    checks++; if (stream_diff(at) != 0) begin errors++; $display("FAIL rstmid_stream got %0d bytes exp %0d first diff %0d", got_q.size(), exp_q.size(), at); end
    checks++; if (pulses() - p0 !== 40'h01_00_00_00_00) begin errors++; $display("FAIL rstmid_pulses got %h exp 0100000000", pulses() - p0); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] p0; bit to; int at, eg, ef, el, ed, kind, gap, nsop, neop, w;
    logic [7:0] da;
    set_addrs(8'h11, 8'h22, 8'h22, 8'h33);  // duplicate address: lowest index must win
    clear_q(); p0 = pulses(); ready_mode = 2;
    eg = 0; ef = 0; el = 0; ed = 0;
    for (int n = 0; n < 60; n++) begin
      w = 0;
      while (exp_q.size() - got_q.size() > DEPTH - 40 && w < 2000) begin tick(); w++; end
      if (w >= 2000) begin checks++; errors++; $display("FAIL b2b_wait got %0d outstanding exp <= %0d", exp_q.size() - got_q.size(), DEPTH - 40); end
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(1, 3);
      da   = addr_tab[$urandom_range(0, 3)];
      case (kind)
        0: begin build_pkt(miss_addr(), 8'($urandom), $urandom_range(1, MAX_LEN), 0); send(pkt.size(), gap); ed++; end
        1: begin build_pkt(da, 8'($urandom), 0, 0); send(pkt.size(), gap); el++; end
        2: begin build_pkt(da, 8'($urandom), $urandom_range(MAX_LEN + 1, 60), 0); send(pkt.size(), gap); el++; end
        3: begin build_pkt(da, 8'($urandom), $urandom_range(1, MAX_LEN), 1); send(pkt.size(), gap); ef++; end
        4: begin build_pkt(da, 8'($urandom), $urandom_range(1, MAX_LEN), 0); send($urandom_range(1, pkt.size() - 1), gap); el++; end
        default: begin build_pkt(da, 8'($urandom), $urandom_range(1, MAX_LEN), 0); push_exp(); send(pkt.size(), gap); eg++; end
      endcase
    end
    drain(to);
    nsop = 0; neop = 0;
    foreach (got_q[i]) begin nsop += int'(got_q[i][9]); neop += int'(got_q[i][8]); end
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got %0d bytes exp %0d", got_q.size(), exp_q.size()); end
    checks++; if (stream_diff(at) != 0) begin errors++; $display("FAIL b2b_stream got %0d bytes exp %0d first diff %0d", got_q.size(), exp_q.size(), at); end
    checks++; if (nsop != eg || neop != eg) begin errors++; $display("FAIL b2b_sop_eop got %0d/%0d exp %0d", nsop, neop, eg); end
    checks++; if (pulses() - p0 !== {8'(eg), 8'(ef), 8'(el), 8'(ed), 8'd0}) begin
      errors++; $display("FAIL b2b_pulses got %h exp %h", pulses() - p0, {8'(eg), 8'(ef), 8'(el), 8'(ed), 8'd0}); end
  endtask

  initial begin
    set_addrs(8'h11, 8'h22, 8'h33, 8'h44);
    test_reset();
    test_good();
    test_bad_fcs();
    test_errors();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
